// File: rtl/ahb_pkg.sv
// Shared AHB slave definitions: transfer/response codes, region tags and FSM encoding.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Haddr[31:26] tags of the three peripheral regions
    localparam logic [5:0] REGION0_TAG = 6'b100000;
    localparam logic [5:0] REGION1_TAG = 6'b100001;
    localparam logic [5:0] REGION2_TAG = 6'b100010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } ahb_state_e;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational region decode of the top address bits; shared with the APB side.
module ahb_addr_decode
    import ahb_pkg::*;
(
    input  logic [5:0] i_haddr_hi,
    output logic [2:0] o_sel,
    output logic       o_unmapped
);

    always_comb begin
        o_sel      = 3'b000;
        o_unmapped = 1'b0;
        case (i_haddr_hi)
            REGION0_TAG: o_sel = 3'b001;
            REGION1_TAG: o_sel = 3'b010;
            REGION2_TAG: o_sel = 3'b100;
            default:     o_unmapped = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB slave front-end of the AHB-to-APB bridge: address-phase capture, backend
// req/ack handshake and timeout-to-ERROR conversion.
//   state | meaning
//   IDLE  | no transfer in data phase, ready for an address phase
//   BUSY  | data phase, bk_req high, waiting for bk_ack or timeout
//   ERR1  | first ERROR cycle, Hreadyout low
//   ERR2  | second ERROR cycle, Hreadyout high, may accept next transfer
module ahb_slave_if
    import ahb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic [31:0]       Haddr,
    input  logic              Hwrite,
    input  logic [1:0]        Htrans,
    input  logic              Hreadyin,
    input  logic [DATA_W-1:0] Hwdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic              bk_req,
    output logic [2:0]        bk_sel,
    output logic [31:0]       bk_addr,
    output logic              bk_write,
    output logic [DATA_W-1:0] bk_wdata,
    input  logic              bk_ack,
    input  logic [DATA_W-1:0] bk_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    ahb_state_e  r_state;
    ahb_state_e  w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [2:0]  r_sel;
    logic [31:0] r_addr;
    logic        r_write;

    logic [2:0]  w_dec_sel;
    logic        w_dec_unmapped;
    logic        w_trans_active;
    logic        w_accept;
    logic        w_load;
    ahb_state_e  w_accept_state;

    ahb_addr_decode u_addr_decode (
        .i_haddr_hi (Haddr[31:26]),
        .o_sel      (w_dec_sel),
        .o_unmapped (w_dec_unmapped)
    );

    assign w_trans_active = (Htrans == HTRANS_NSEQ) || (Htrans == HTRANS_SEQ);
    assign w_accept       = Hreadyin & w_trans_active & Hreadyout;
    assign w_accept_state = w_dec_unmapped ? ST_ERR1 : ST_BUSY;

    // Bus-facing outputs are decoded from state so reset clears them asynchronously
    assign Hreadyout = (r_state == ST_BUSY) ? bk_ack : (r_state != ST_ERR1);
    assign Hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign Hrdata    = ((r_state == ST_BUSY) && bk_ack && !r_write) ? bk_rdata : '0;
    assign bk_req    = (r_state == ST_BUSY);
    assign bk_wdata  = bk_req ? Hwdata : '0;
    assign bk_sel    = r_sel;
    assign bk_addr   = r_addr;
    assign bk_write  = r_write;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    w_state_nxt = w_accept_state;
                    w_load      = !w_dec_unmapped;
                end
            end
            ST_BUSY: begin
                if (bk_ack) begin
                    w_state_nxt = ST_IDLE;
                    if (w_accept) begin
                        w_state_nxt = w_accept_state;
                        w_load      = !w_dec_unmapped;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = ST_ERR1;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_load) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_sel   <= w_dec_sel;
                r_addr  <= Haddr;
                r_write <= Hwrite;
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Scoreboard bench for ahb_slave_if: expected completions/errors are queued at
// the address phase and retired by a monitor when the DUT responds.
module tb_ahb_slave_if;
    import ahb_pkg::*;

    logic        Hclk;
    logic        Hresetn;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [1:0]  Htrans;
    logic        Hreadyin;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic        bk_req;
    logic [2:0]  bk_sel;
    logic [31:0] bk_addr;
    logic        bk_write;
    logic [31:0] bk_wdata;
    logic        bk_ack;
    logic [31:0] bk_rdata;

    typedef struct {
        logic        is_err;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   req_cycles  = 0;
    int   wait_cycles = 0;

    ahb_slave_if #(.DATA_W(32), .TIMEOUT(16)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Haddr     (Haddr),
        .Hwrite    (Hwrite),
        .Htrans    (Htrans),
        .Hreadyin  (Hreadyin),
        .Hwdata    (Hwdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .bk_req    (bk_req),
        .bk_sel    (bk_sel),
        .bk_addr   (bk_addr),
        .bk_write  (bk_write),
        .bk_wdata  (bk_wdata),
        .bk_ack    (bk_ack),
        .bk_rdata  (bk_rdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic push_exp(input logic is_err, input logic [31:0] addr, input logic wr,
                            input logic [2:0] sel, input logic [31:0] data);
        exp_t e;
        e.is_err = is_err;
        e.addr   = addr;
        e.wr     = wr;
        e.sel    = sel;
        e.data   = data;
        sb_q.push_back(e);
    endtask

    // Monitor: retire one scoreboard entry per completion or per ERR1 cycle
    always @(negedge Hclk) begin
        if (Hresetn) begin
            exp_t e;
            if (bk_req) req_cycles++;
            if (!Hreadyout) wait_cycles++;
            if ((bk_req && bk_ack) || (Hresp == HRESP_ERROR && !Hreadyout)) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_kind", 64'(Hresp[0]), 64'(e.is_err));
                    if (!e.is_err) begin
                        chk("sb_addr", 64'(bk_addr), 64'(e.addr));
                        chk("sb_write", 64'(bk_write), 64'(e.wr));
                        chk("sb_sel", 64'(bk_sel), 64'(e.sel));
                        chk("sb_ready", 64'(Hreadyout), 64'd1);
                        if (e.wr) chk("sb_wdata", 64'(bk_wdata), 64'(e.data));
                        else      chk("sb_rdata", 64'(Hrdata), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int w0;
        Hresetn  = 1'b0;
        Haddr    = '0;
        Hwrite   = 1'b0;
        Htrans   = HTRANS_IDLE;
        Hreadyin = 1'b1;
        Hwdata   = '0;
        bk_ack   = 1'b0;
        bk_rdata = '0;
        repeat (3) tick();
        @(negedge Hclk);
        chk("rst_ready", 64'(Hreadyout), 64'd1);
        chk("rst_resp", 64'(Hresp), 64'd0);
        chk("rst_rdata", 64'(Hrdata), 64'd0);
        chk("rst_req", 64'(bk_req), 64'd0);
        chk("rst_sel", 64'(bk_sel), 64'd0);
        chk("rst_addr", 64'(bk_addr), 64'd0);
        chk("rst_write", 64'(bk_write), 64'd0);
        chk("rst_wdata", 64'(bk_wdata), 64'd0);
        tick();
        Hresetn = 1'b1;
        tick();

        // IDLE/BUSY transfers and Hreadyin=0 are never accepted
        Haddr  = 32'h8000_0000;
        Htrans = HTRANS_BUSY;
        tick();
        Htrans   = HTRANS_NSEQ;
        Hreadyin = 1'b0;
        @(negedge Hclk);
        chk("busy_ignored", 64'(bk_req), 64'd0);
        tick();
        Htrans   = HTRANS_IDLE;
        Hreadyin = 1'b1;
        @(negedge Hclk);
        chk("notready_ignored", 64'(bk_req), 64'd0);

        // Single zero-wait read
        tick();
        Haddr = 32'h8000_0001; Hwrite = 1'b0; Htrans = HTRANS_NSEQ;
        bk_ack = 1'b1; bk_rdata = 32'hDEAD_BEEF;
        push_exp(1'b0, 32'h8000_0001, 1'b0, 3'b001, 32'hDEAD_BEEF);
        tick();
        Htrans = HTRANS_IDLE;
        @(negedge Hclk);
        chk("rd_req", 64'(bk_req), 64'd1);
        chk("rd_rdata", 64'(Hrdata), 64'hDEAD_BEEF);
        tick();
        @(negedge Hclk);
        chk("rd_req_drop", 64'(bk_req), 64'd0);
        chk("rd_rdata_idle", 64'(Hrdata), 64'd0);
        bk_ack = 1'b0;

        // Single write with three wait states
        tick();
        w0 = wait_cycles;
        Haddr = 32'h8000_1001; Hwrite = 1'b1; Htrans = HTRANS_NSEQ; Hwdata = 32'h8000_0111;
        push_exp(1'b0, 32'h8000_1001, 1'b1, 3'b001, 32'h8000_0111);
        tick();
        Htrans = HTRANS_IDLE;
        for (int i = 0; i < 3; i++) begin
            @(negedge Hclk);
            chk("wr_wait_ready", 64'(Hreadyout), 64'd0);
            chk("wr_wait_wdata", 64'(bk_wdata), 64'h8000_0111);
            tick();
        end
        bk_ack = 1'b1;
        tick();
        bk_ack = 1'b0;
        chk("wr_wait_count", 64'(wait_cycles - w0), 64'd3);
        @(negedge Hclk);
        chk("wr_wdata_gated", 64'(bk_wdata), 64'd0);

        // INCR4 write burst, zero wait
        r0 = req_cycles;
        w0 = wait_cycles;
        bk_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            Haddr  = 32'h8000_1000 + 32'(4 * i);
            Hwrite = 1'b1;
            Htrans = (i == 0) ? HTRANS_NSEQ : HTRANS_SEQ;
            Hwdata = 32'hA000_0000 + 32'(i - 1);
            push_exp(1'b0, 32'h8000_1000 + 32'(4 * i), 1'b1, 3'b001, 32'hA000_0000 + 32'(i));
        end
        tick();
        Htrans = HTRANS_IDLE;
        Hwdata = 32'hA000_0003;
        tick();
        bk_ack = 1'b0;
        tick();
        chk("burst_req_cycles", 64'(req_cycles - r0), 64'd4);
        chk("burst_waits", 64'(wait_cycles - w0), 64'd0);

        // Unmapped access, then mapped accept in ERR2
        Haddr = 32'h9000_0000; Hwrite = 1'b0; Htrans = HTRANS_NSEQ;
        push_exp(1'b1, 32'h0, 1'b0, 3'b000, 32'h0);
        tick();
        Htrans = HTRANS_IDLE;
        @(negedge Hclk);
        chk("err1_resp", 64'(Hresp), 64'(HRESP_ERROR));
        chk("err1_ready", 64'(Hreadyout), 64'd0);
        chk("err1_req", 64'(bk_req), 64'd0);
        tick();
        Haddr = 32'h8400_0000; Hwrite = 1'b0; Htrans = HTRANS_NSEQ;
        bk_ack = 1'b1; bk_rdata = 32'h1234_5678;
        push_exp(1'b0, 32'h8400_0000, 1'b0, 3'b010, 32'h1234_5678);
        @(negedge Hclk);
        chk("err2_resp", 64'(Hresp), 64'(HRESP_ERROR));
        chk("err2_ready", 64'(Hreadyout), 64'd1);
        tick();
        Htrans = HTRANS_IDLE;
        @(negedge Hclk);
        chk("err2_accept_sel", 64'(bk_sel), 64'b010);
        tick();
        bk_ack = 1'b0;

        // Timeout: no ack for 16 data cycles
        r0 = req_cycles;
        Haddr = 32'h8800_0000; Hwrite = 1'b0; Htrans = HTRANS_NSEQ;
        push_exp(1'b1, 32'h0, 1'b0, 3'b000, 32'h0);
        tick();
        Htrans = HTRANS_IDLE;
        @(negedge Hclk);
        chk("to_sel", 64'(bk_sel), 64'b100);
        repeat (16) tick();
        @(negedge Hclk);
        chk("to_err1", 64'({Hreadyout, Hresp}), 64'({1'b0, HRESP_ERROR}));
        tick();
        @(negedge Hclk);
        chk("to_err2", 64'({Hreadyout, Hresp}), 64'({1'b1, HRESP_ERROR}));
        tick();
        chk("to_req_cycles", 64'(req_cycles - r0), 64'd16);

        // Ack on the 16th data cycle wins over the timeout
        r0 = req_cycles;
        Haddr = 32'h8800_0004; Hwrite = 1'b0; Htrans = HTRANS_NSEQ; bk_rdata = 32'hCAFE_F00D;
        push_exp(1'b0, 32'h8800_0004, 1'b0, 3'b100, 32'hCAFE_F00D);
        tick();
        Htrans = HTRANS_IDLE;
        repeat (15) tick();
        bk_ack = 1'b1;
        @(negedge Hclk);
        chk("to_ack_ok", 64'({Hreadyout, Hresp}), 64'({1'b1, HRESP_OKAY}));
        tick();
        bk_ack = 1'b0;
        @(negedge Hclk);
        chk("to_ack_no_err", 64'(Hresp), 64'(HRESP_OKAY));
        tick();
        chk("to_ack_req_cycles", 64'(req_cycles - r0), 64'd16);

        // Reset in the middle of a waited transfer
        Haddr = 32'h8000_0010; Hwrite = 1'b1; Htrans = HTRANS_NSEQ;
        tick();
        Htrans = HTRANS_IDLE;
        tick();
        chk("rstmid_busy", 64'(bk_req), 64'd1);
        #2 Hresetn = 1'b0;
        #1;
        chk("rstmid_req", 64'(bk_req), 64'd0);
        chk("rstmid_ready", 64'(Hreadyout), 64'd1);
        tick();
        Hresetn = 1'b1;
        tick();
        @(negedge Hclk);
        chk("post_rst_req", 64'(bk_req), 64'd0);
        chk("post_rst_addr", 64'(bk_addr), 64'd0);
        chk("post_rst_resp", 64'({Hreadyout, Hresp}), 64'({1'b1, HRESP_OKAY}));
        tick();

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
AHB slave front-end of the AHB-to-APB bridge. It responds to transfers from the AHB master by sampling the address phase and decoding it to one of three peripheral regions. It then drives a request/acknowledge handshake toward the APB-side backend and returns Hreadyout, Hresp and Hrdata. A timeout counter converts a backend that never acknowledges into an AHB two-cycle ERROR response.

Parameters:
DATA_W, 32, Hwdata/Hrdata width
TIMEOUT, 16, maximum data-phase cycles without bk_ack before ERROR (legal range 2..255)

Ports:
Hclk  input  1  clock, rising edge
Hresetn  input  1  asynchronous active-low reset
Haddr  input  32  address-phase address
Hwrite  input  1  1=write, 0=read
Htrans  input  2  00 IDLE, 01 BUSY, 10 NSEQ, 11 SEQ
Hreadyin  input  1  previous transfer complete on bus
Hwdata  input  DATA_W  write data, valid in data phase
Hreadyout  output  1  slave ready / transfer complete
Hresp  output  2  00 OKAY, 01 ERROR
Hrdata  output  DATA_W  read data
bk_req  output  1  backend request, held until ack or timeout
bk_sel  output  3  one-hot region select, registered
bk_addr  output  32  registered address
bk_write  output  1  registered direction
bk_wdata  output  DATA_W  equals Hwdata while bk_req=1, else 0
bk_ack  input  1  backend completes current request
bk_rdata  input  DATA_W  backend read data, valid with bk_ack

Behaviour:
- Clock and reset: one clock, Hclk. Hresetn is asynchronous and active-low.
- Reset values: Hreadyout=1, Hresp=00, Hrdata=0, bk_req=0, bk_sel=000, bk_addr=0, bk_write=0, state IDLE, timeout counter=0.
- Reset asserted mid-transfer aborts the transfer immediately; bk_req drops asynchronously.
- Address decode on Haddr[31:26]:
  - 100000 -> sel 001 (0x8000_0000..0x83FF_FFFF)
  - 100001 -> sel 010
  - 100010 -> sel 100
  - any other value -> unmapped.
- Accept condition: Hreadyin=1 AND Htrans[1]=1 AND Hreadyout=1 at the rising edge. Htrans IDLE/BUSY are never accepted and leave state unchanged.
- States: IDLE, BUSY, ERR1, ERR2.
- IDLE:
  - Hreadyout=1, Hresp=00.
  - Accept of a mapped address -> BUSY; load bk_addr, bk_write, bk_sel; bk_req=1 from the next cycle; timeout counter cleared.
  - Accept of an unmapped address -> ERR1; bk_req stays 0.
- BUSY (data phase):
  - Hreadyout = bk_ack, Hresp=00, Hrdata = bk_rdata when bk_ack=1 and bk_write=0, else 0.
  - Each cycle with bk_ack=0 increments the counter.
  - bk_ack=1: the transfer completes this cycle; bk_req falls next cycle unless a new transfer is accepted in the same cycle.
  - Back-to-back: when bk_ack=1 and a mapped accept occur together, the next state is BUSY with new registers loaded and bk_req held at 1 continuously. An unmapped accept in that cycle -> ERR1. No accept -> IDLE.
  - Counter reaching TIMEOUT-1 with bk_ack=0 -> ERR1; bk_req drops next cycle.
  - bk_ack arriving in the same cycle as the timeout takes priority (normal completion).
- ERR1: Hreadyout=0, Hresp=01; always -> ERR2. Address phases are not accepted because Hreadyout=0.
- ERR2:
  - Hreadyout=1, Hresp=01.
  - An accept here is processed as in IDLE (mapped -> BUSY, unmapped -> ERR1); otherwise -> IDLE.
- Zero-wait latency: address phase in cycle N, bk_req in N+1, completion in N+1 if bk_ack=1 in N+1.
- bk_ack while bk_req=0 is ignored.
- Write data: the master holds Hwdata stable while Hreadyout=0, so bk_wdata is a gated pass-through, not a flop.
- Timeout counter: width 8, saturating; no wrap-around occurs within the legal TIMEOUT range.

Decomposition:
- Shared package ahb_pkg holds:
  - Htrans codes (IDLE, BUSY, NSEQ, SEQ)
  - Hresp codes (OKAY=00, ERROR=01)
  - region base tags (6'b100000, 6'b100001, 6'b100010)
  - state encoding for IDLE, BUSY, ERR1, ERR2.
- One sub-module, ahb_addr_decode: combinational Haddr -> {sel[2:0], unmapped}, reused by the bridge's APB side.
- FSM and counter stay in ahb_slave_if.

Test Plan:
- Single read: Haddr=0x8000_0001, Hwrite=0, NSEQ, bk_ack=1 with bk_rdata=0xDEAD_BEEF on the first data cycle -> bk_sel=001, bk_req one cycle, Hreadyout=1 with Hrdata=0xDEAD_BEEF, Hresp=00.
- Single write with wait: Haddr=0x8000_1001, Hwdata=0x8000_0111, bk_ack delayed 3 cycles -> Hreadyout low 3 cycles, bk_wdata=0x8000_0111 throughout, bk_write=1, completion on the 4th data cycle.
- INCR4 write burst 0x8000_1000, 0x8000_1004, 0x8000_1008, 0x8000_100C, NSEQ then SEQ x3, bk_ack always 1 -> bk_req high continuously for 4 cycles, bk_addr steps by 4, no wait states.
- Unmapped access: Haddr=0x9000_0000 NSEQ -> bk_req never asserts; Hresp=01 for 2 cycles with Hreadyout 0 then 1. A following NSEQ to 0x8400_0000 accepted in ERR2 -> bk_sel=010.
- Timeout: TIMEOUT=16, bk_ack held 0 -> bk_req high 16 cycles then drops, followed by ERR1 and ERR2. Repeat with bk_ack on cycle 16 -> OKAY completion.
- Reset mid-BUSY: deassert Hresetn during the wait -> bk_req=0, Hreadyout=1 asynchronously. After release, IDLE with no stale request.
